// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
//   Shared definitions for the fetch-stage program counter.
//   - pc_state_e : fetch state encoding (BOOT, FETCH, HALTED)
//   - PC_DEFAULT_WIDTH / PC_DEFAULT_STEP / PC_DEFAULT_RAS_DEPTH :
//     default parameter values used by program_counter
// ---------------------------------------------------------------------------
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  localparam int PC_DEFAULT_WIDTH     = 8;
  localparam int PC_DEFAULT_STEP      = 1;
  localparam int PC_DEFAULT_RAS_DEPTH = 4;

endpackage

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
//   Circular return-address stack of DEPTH entries, WIDTH bits each.
//   A push onto a full stack overwrites the oldest entry (the write pointer
//   simply keeps circling); a pop from an empty stack is ignored.
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (empties the stack)
//   push       in   write push_data on top (has priority over pop)
//   pop        in   remove the top entry
//   push_data  in   WIDTH  value to push
//   top_data   out  WIDTH  current top entry (valid when !empty)
//   full       out  stack holds DEPTH entries
//   empty      out  stack holds no entries
// ---------------------------------------------------------------------------
module ras_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    top_idx;

  // ptr_q is the next free slot, so the top lives one slot behind it.
  assign top_idx  = (ptr_q == '0) ? PTR_LAST : ptr_q - 1'b1;
  assign top_data = mem_q[top_idx];
  assign full     = (count_q == CNT_DEPTH);
  assign empty    = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[ptr_q] = push_data;
      ptr_d        = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      // Count saturates: overflow discards the oldest entry.
      if (!full) count_d = count_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d   = top_idx;
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being pushed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/program_counter.sv
// ---------------------------------------------------------------------------
// program_counter
//   Fetch-stage program counter. Holds the current fetch address, presents it
//   to instruction memory with VALID/ACK, advances on accepted fetches,
//   redirects on branches and freezes on STALL or HALT.
//   Optional return-address stack enabled by defining macro PC_RAS_EN.
// Ports
//   CLK        in   clock, rising edge
//   R          in   synchronous active-high reset
//   STALL      in   downstream stall, blocks PC advance
//   BR_EN      in   branch/jump redirect request
//   BR_TARGET  in   WIDTH  redirect address
//   HALT       in   enter HALTED
//   ACK        in   imem accepted current fetch
//   CALL       in   push return address and jump (PC_RAS_EN only)
//   RET        in   pop return address into PC (PC_RAS_EN only)
//   PC         out  WIDTH  current fetch address
//   PC_NEXT    out  WIDTH  PC+STEP modulo 2^WIDTH
//   VALID      out  PC is a live fetch request
//   RAS_ERR    out  sticky stack underflow/overflow flag
// ---------------------------------------------------------------------------
module program_counter
  import pc_pkg::*;
#(
  parameter int WIDTH        = PC_DEFAULT_WIDTH,
  parameter int RESET_VECTOR = 0,
  parameter int STEP         = PC_DEFAULT_STEP,
  parameter int RAS_DEPTH    = PC_DEFAULT_RAS_DEPTH
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             STALL,
  input  logic             BR_EN,
  input  logic [WIDTH-1:0] BR_TARGET,
  input  logic             HALT,
  input  logic             ACK,
  input  logic             CALL,
  input  logic             RET,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_NEXT,
  output logic             VALID,
  output logic             RAS_ERR
);

  localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  // Truncation to WIDTH gives the modulo-2^WIDTH wrap.
  assign PC_NEXT = pc_q + STEP_W;
  assign PC      = pc_q;
  assign VALID   = (state_q == ST_FETCH);

`ifdef PC_RAS_EN
  logic             ras_push, ras_pop, ras_full, ras_empty;
  logic [WIDTH-1:0] ras_top;
  logic             ras_err_q, ras_err_d;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (WIDTH)
  ) u_ras (
    .clk       (CLK),
    .rst       (R),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PC_NEXT),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Sticky error: any push into a full stack or pop from an empty one.
  always_comb begin
    ras_err_d = ras_err_q | (ras_push & ras_full) | (ras_pop & ras_empty);
  end

  always_ff @(posedge CLK) begin
    if (R) ras_err_q <= 1'b0;
    else   ras_err_q <= ras_err_d;
  end

  assign RAS_ERR = ras_err_q;
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ras_inputs;
  assign unused_ras_inputs = CALL ^ RET;
  assign RAS_ERR = 1'b0;
`endif

  // Next-state / next-PC. Branch beats everything (a same-cycle ACK is lost),
  // then call/return, then halt, then an accepted, unstalled fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_RAS_EN
    ras_push = 1'b0;
    ras_pop  = 1'b0;
`endif
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (BR_EN) begin
          pc_d = BR_TARGET;
`ifdef PC_RAS_EN
        end else if (CALL) begin
          ras_push = 1'b1;
          pc_d     = BR_TARGET;
        end else if (RET) begin
          ras_pop = 1'b1;
          pc_d    = ras_empty ? RESET_PC : ras_top;
`endif
        end else if (HALT) begin
          state_d = ST_HALTED;
        end else if (ACK && !STALL) begin
          pc_d = PC_NEXT;
        end
      end
      ST_HALTED: begin
        if (BR_EN) begin
          pc_d    = BR_TARGET;
          state_d = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_program_counter.sv
// ---------------------------------------------------------------------------
// tb_program_counter
//   Self-checking bench for program_counter (WIDTH=8, RESET_VECTOR=0,
//   STEP=1, RAS_DEPTH=4). A behavioural model tracks the expected PC,
//   liveness and stack contents from the input rules alone.
// ---------------------------------------------------------------------------
module tb_program_counter;

  localparam int W  = 8;
  localparam int RV = 0;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         r = 1'b1;
  logic         stall = 1'b0;
  logic         br_en = 1'b0;
  logic [W-1:0] br_target = '0;
  logic         halt = 1'b0;
  logic         ack = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] pc, pc_next;
  logic         valid, ras_err;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state
  logic [W-1:0] m_pc = W'(RV);
  bit           m_live = 1'b0;
  bit           m_boot = 1'b1;
  bit           m_err  = 1'b0;
  logic [W-1:0] m_stack [$];

  program_counter #(
    .WIDTH        (W),
    .RESET_VECTOR (RV),
    .STEP         (1),
    .RAS_DEPTH    (RD)
  ) dut (
    .CLK       (clk),
    .R         (r),
    .STALL     (stall),
    .BR_EN     (br_en),
    .BR_TARGET (br_target),
    .HALT      (halt),
    .ACK       (ack),
    .CALL      (call),
    .RET       (ret),
    .PC        (pc),
    .PC_NEXT   (pc_next),
    .VALID     (valid),
    .RAS_ERR   (ras_err)
  );

  always #5 clk = ~clk;

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_update();
    if (r) begin
      m_pc   = W'(RV);
      m_boot = 1'b1;
      m_live = 1'b0;
      m_err  = 1'b0;
      m_stack.delete();
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_live = 1'b1;
    end else if (m_live) begin
      if (br_en) m_pc = br_target;
`ifdef PC_RAS_EN
      else if (call) begin
        m_stack.push_back(W'(m_pc + 1));
        if (m_stack.size() > RD) begin
          void'(m_stack.pop_front());
          m_err = 1'b1;
        end
        m_pc = br_target;
      end else if (ret) begin
        if (m_stack.size() == 0) begin
          m_pc  = W'(RV);
          m_err = 1'b1;
        end else begin
          m_pc = m_stack.pop_back();
        end
      end
`endif
      else if (halt) m_live = 1'b0;
      else if (ack && !stall) m_pc = W'(m_pc + 1);
    end else begin
      if (br_en) begin
        m_pc   = br_target;
        m_live = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    r = 1'b0; stall = 1'b0; br_en = 1'b0; halt = 1'b0;
    ack = 1'b0; call = 1'b0; ret = 1'b0; br_target = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    r = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (pc !== 8'h00 || valid !== 1'b0) begin
        $display("[TB] FAIL reset_hold: pc=%h valid=%b, want pc=00 valid=0", pc, valid);
        miscompares++;
      end
    end
    r = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || ras_err !== 1'b0) begin
      $display("[TB] FAIL reset_bubble: valid=%b ras_err=%b, want 0 0", valid, ras_err);
      miscompares++;
    end
    tick();
    vectors++;
    if (pc !== 8'h00 || valid !== 1'b1) begin
      $display("[TB] FAIL reset_to_fetch: pc=%h valid=%b, want pc=00 valid=1", pc, valid);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_seq [4];
    exp_seq[0] = 8'hFE; exp_seq[1] = 8'hFF; exp_seq[2] = 8'h00; exp_seq[3] = 8'h01;
    idle_inputs();
    br_en = 1'b1; br_target = 8'hFD;
    tick();
    vectors++;
    if (pc !== 8'hFD) begin
      $display("[TB] FAIL wrap_setup: pc=%h, want FD", pc);
      miscompares++;
    end
    br_en = 1'b0; ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (pc !== exp_seq[i] || pc !== m_pc) begin
        $display("[TB] FAIL wrap_seq%0d: pc=%h, want %h", i, pc, exp_seq[i]);
        miscompares++;
      end
      vectors++;
      if (pc_next !== W'(exp_seq[i] + 1)) begin
        $display("[TB] FAIL wrap_pc_next%0d: pc_next=%h, want %h", i, pc_next, W'(exp_seq[i] + 1));
        miscompares++;
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] start_pc;
    idle_inputs();
    start_pc = m_pc;
    ack = 1'b1; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (pc !== start_pc || valid !== 1'b1) begin
        $display("[TB] FAIL stall_hold%0d: pc=%h valid=%b, want %h 1", i, pc, valid, start_pc);
        miscompares++;
      end
    end
    stall = 1'b0;
    tick();
    vectors++;
    if (pc !== W'(start_pc + 1)) begin
      $display("[TB] FAIL stall_release: pc=%h, want %h", pc, W'(start_pc + 1));
      miscompares++;
    end
  endtask

  task automatic test_branch_halt();
    idle_inputs();
    br_en = 1'b1; br_target = 8'h40; ack = 1'b1; halt = 1'b1; stall = 1'b1;
    tick();
    vectors++;
    if (pc !== 8'h40 || valid !== 1'b1) begin
      $display("[TB] FAIL branch_priority: pc=%h valid=%b, want 40 1", pc, valid);
      miscompares++;
    end
    br_en = 1'b0; stall = 1'b0; ack = 1'b0;
    tick();
    vectors++;
    if (pc !== 8'h40 || valid !== 1'b0) begin
      $display("[TB] FAIL halt_enter: pc=%h valid=%b, want 40 0", pc, valid);
      miscompares++;
    end
    for (int i = 0; i < 4; i++) begin
      halt = 1'($urandom_range(0, 1));
      ack  = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if (pc !== 8'h40 || valid !== 1'b0) begin
        $display("[TB] FAIL halted_hold%0d: pc=%h valid=%b, want 40 0", i, pc, valid);
        miscompares++;
      end
    end
    halt = 1'b0; ack = 1'b0;
    br_en = 1'b1; br_target = 8'h10;
    tick();
    vectors++;
    if (pc !== 8'h10 || valid !== 1'b1) begin
      $display("[TB] FAIL halt_exit: pc=%h valid=%b, want 10 1", pc, valid);
      miscompares++;
    end
    idle_inputs();
  endtask

`ifdef PC_RAS_EN
  task automatic test_ras();
    idle_inputs();
    br_en = 1'b1; br_target = 8'h05;
    tick();
    br_en = 1'b0; call = 1'b1; ret = 1'b1; br_target = 8'h20;
    tick();
    vectors++;
    if (pc !== 8'h20 || ras_err !== 1'b0) begin
      $display("[TB] FAIL ras_call: pc=%h err=%b, want 20 0", pc, ras_err);
      miscompares++;
    end
    call = 1'b0;
    tick();
    vectors++;
    if (pc !== 8'h06) begin
      $display("[TB] FAIL ras_ret: pc=%h, want 06", pc);
      miscompares++;
    end
    tick();
    vectors++;
    if (pc !== 8'h00 || ras_err !== 1'b1) begin
      $display("[TB] FAIL ras_underflow: pc=%h err=%b, want 00 1", pc, ras_err);
      miscompares++;
    end
    ret = 1'b0; br_en = 1'b1; br_target = 8'h33;
    tick();
    vectors++;
    if (ras_err !== 1'b1) begin
      $display("[TB] FAIL ras_sticky: err=%b, want 1", ras_err);
      miscompares++;
    end
    idle_inputs();
    r = 1'b1;
    tick();
    vectors++;
    if (ras_err !== 1'b0) begin
      $display("[TB] FAIL ras_clear: err=%b, want 0", ras_err);
      miscompares++;
    end
    r = 1'b0;
    tick();
  endtask
`endif

  task automatic test_reset_mid_fetch();
    idle_inputs();
    ack = 1'b1;
    tick();
    r = 1'b1; br_en = 1'b1; br_target = 8'h77;
    tick();
    vectors++;
    if (pc !== W'(RV) || valid !== 1'b0) begin
      $display("[TB] FAIL reset_mid_fetch: pc=%h valid=%b, want %h 0", pc, valid, W'(RV));
      miscompares++;
    end
    r = 1'b0; br_en = 1'b0; ack = 1'b0;
    tick();
    vectors++;
    if (pc !== W'(RV) || valid !== 1'b1) begin
      $display("[TB] FAIL reset_branch_lost: pc=%h valid=%b, want %h 1", pc, valid, W'(RV));
      miscompares++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      r         = ($urandom_range(0, 39) == 0);
      br_en     = ($urandom_range(0, 7) == 0);
      halt      = ($urandom_range(0, 9) == 0);
      ack       = 1'($urandom_range(0, 1));
      stall     = ($urandom_range(0, 3) == 0);
      call      = ($urandom_range(0, 11) == 0);
      ret       = ($urandom_range(0, 11) == 0);
      br_target = W'($urandom);
      tick();
      vectors++;
      if (pc !== m_pc) begin
        $display("[TB] FAIL rand_pc cycle %0d: pc=%h, want %h", i, pc, m_pc);
        miscompares++;
      end
      vectors++;
      if (valid !== m_live) begin
        $display("[TB] FAIL rand_valid cycle %0d: valid=%b, want %b", i, valid, m_live);
        miscompares++;
      end
      vectors++;
      if (pc_next !== W'(m_pc + 1)) begin
        $display("[TB] FAIL rand_pc_next cycle %0d: pc_next=%h, want %h", i, pc_next, W'(m_pc + 1));
        miscompares++;
      end
      vectors++;
      if (ras_err !== m_err) begin
        $display("[TB] FAIL rand_ras_err cycle %0d: err=%b, want %b", i, ras_err, m_err);
        miscompares++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    $display("[TB] program_counter bench start");
    test_reset();
    test_wrap();
    test_stall();
    test_branch_halt();
`ifdef PC_RAS_EN
    test_ras();
`endif
    test_reset_mid_fetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
